// File: rtl/sd_cmd_engine.sv
`timescale 1ns/1ps
// sd_cmd_engine
// Command-line engine for an SD card in SPI-less (native) mode on the
// IceSugar-Nano microSD path. It divides CLK down to SD_CLK and sends the
// power-up clock burst. It then serialises 48-bit command frames with CRC7 on
// CMD and captures no response, a 48-bit response or a 136-bit response.
//
// Ports
//   CLK        system clock, all logic on the rising edge
//   RST        synchronous active-high reset
//   START      transaction request, honoured only while BUSY=0
//   CMD_IDX    command index, latched when START is accepted
//   CMD_ARG    command argument, latched when START is accepted
//   RESP_TYPE  00/11 none, 01 48-bit response, 10 136-bit (R2) response
//   SD_CLK     divided card clock
//   CMD_OUT    value driven onto CMD while CMD_OE=1
//   CMD_OE     1 drives CMD, 0 releases it to the pull-up
//   CMD_IN     sampled CMD line
//   BUSY       high in every state except IDLE
//   DONE       one-CLK pulse when a transaction finishes
//   TIMEOUT    sticky, card start bit missing after RESP_TIMEOUT rises
//   CRC_ERR    sticky, 48-bit CRC7 mismatch or end bit 0
//   RESP       captured response payload
module sd_cmd_engine #(
    parameter int CLK_DIV      = 60,
    parameter int INIT_CLOCKS  = 80,
    parameter int RESP_TIMEOUT = 64,
    parameter int GAP_CLOCKS   = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [5:0]   CMD_IDX,
    input  logic [31:0]  CMD_ARG,
    input  logic [1:0]   RESP_TYPE,
    output logic         SD_CLK,
    output logic         CMD_OUT,
    output logic         CMD_OE,
    input  logic         CMD_IN,
    output logic         BUSY,
    output logic         DONE,
    output logic         TIMEOUT,
    output logic         CRC_ERR,
    output logic [127:0] RESP
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MAX_A   = (INIT_CLOCKS > RESP_TIMEOUT) ? INIT_CLOCKS : RESP_TIMEOUT;
    localparam int MAX_B   = (GAP_CLOCKS > 136) ? GAP_CLOCKS : 136;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RESP,
        ST_RECV,
        ST_GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DIV_W-1:0]   div_cnt;
    logic               div_wrap;
    logic               rise_tick;
    logic               fall_tick;
    logic [CNT_W-1:0]   step_cnt;
    logic               step_event;
    logic [47:0]        tx_sr;
    logic [126:0]       rx_sr;
    logic [127:0]       rx_next;
    logic               has_resp;
    logic               long_resp;
    logic               last_rx_bit;

    // CRC7 with polynomial x^7 + x^3 + 1, zero seed, fed MSB first.
    function automatic logic [6:0] crc7_calc(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    // Full command frame: start bit, transmission bit, index, argument,
    // CRC7 over the first 40 bits, and the end bit.
    function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] head;
        head = {2'b01, idx, arg};
        return {head, crc7_calc(head), 1'b1};
    endfunction

    // Free-running divider. A tick is the CLK cycle where SD_CLK is about to
    // toggle, so the FSM acts on the same edge as the card clock changes.
    assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick = div_wrap & ~SD_CLK;
    assign fall_tick = div_wrap & SD_CLK;

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt <= '0;
            SD_CLK  <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            SD_CLK  <= ~SD_CLK;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // The incoming bit is appended before the final compare, so the checks
    // at the last bit look at the complete response.
    assign rx_next     = {rx_sr, CMD_IN};
    assign last_rx_bit = (step_cnt == (long_resp ? CNT_W'(134) : CNT_W'(46)));

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Every state advances only on SD_CLK ticks except
    // IDLE, which reacts to START immediately.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: begin
                if (rise_tick && step_cnt == CNT_W'(INIT_CLOCKS - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (START) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (fall_tick && step_cnt == CNT_W'(48)) begin
                    state_next = has_resp ? ST_WAIT_RESP : ST_GAP;
                end
            end
            ST_WAIT_RESP: begin
                if (rise_tick) begin
                    if (!CMD_IN) begin
                        state_next = ST_RECV;
                    end else if (step_cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_RECV: begin
                if (rise_tick && last_rx_bit) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (rise_tick && step_cnt == CNT_W'(GAP_CLOCKS - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Output decode.
    always_comb begin
        BUSY = (state != ST_IDLE);
    end

    // SEND counts falling edges (one bit driven per fall), the other states
    // count rising edges. The counter restarts on every state change.
    assign step_event = (state == ST_SEND) ? fall_tick : rise_tick;

    // Datapath: frame shifter, response capture, sticky flags and DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CMD_OUT   <= 1'b1;
            CMD_OE    <= 1'b0;
            DONE      <= 1'b0;
            TIMEOUT   <= 1'b0;
            CRC_ERR   <= 1'b0;
            RESP      <= '0;
            step_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            has_resp  <= 1'b0;
            long_resp <= 1'b0;
        end else begin
            DONE <= 1'b0;

            if (state_next != state) begin
                step_cnt <= '0;
            end else if (state != ST_IDLE && step_event) begin
                step_cnt <= step_cnt + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (START) begin
                        has_resp  <= (RESP_TYPE == 2'b01) || (RESP_TYPE == 2'b10);
                        long_resp <= (RESP_TYPE == 2'b10);
                        tx_sr     <= build_frame(CMD_IDX, CMD_ARG);
                        TIMEOUT   <= 1'b0;
                        CRC_ERR   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (fall_tick) begin
                        if (step_cnt == CNT_W'(48)) begin
                            CMD_OE  <= 1'b0;
                            CMD_OUT <= 1'b1;
                        end else begin
                            CMD_OE  <= 1'b1;
                            CMD_OUT <= tx_sr[47];
                            tx_sr   <= {tx_sr[46:0], 1'b0};
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (rise_tick) begin
                        // Clearing here leaves the start bit as a zero above
                        // the captured bits, so a short response lines up as
                        // a full 48-bit frame at rx_next[47:0].
                        if (!CMD_IN) begin
                            rx_sr <= '0;
                        end else if (step_cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
                            TIMEOUT <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (rise_tick) begin
                        rx_sr <= rx_next[126:0];
                        if (last_rx_bit) begin
                            if (long_resp) begin
                                RESP    <= {rx_next[127:1], 1'b0};
                                CRC_ERR <= ~rx_next[0];
                            end else begin
                                RESP    <= {90'b0, rx_next[45:8]};
                                CRC_ERR <= ~rx_next[0] |
                                           (crc7_calc(rx_next[47:8]) != rx_next[7:1]);
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (rise_tick && step_cnt == CNT_W'(GAP_CLOCKS - 1)) begin
                        DONE <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
`timescale 1ns/1ps
// tb_sd_cmd_engine
// Directed bench for sd_cmd_engine with CLK_DIV=2 (SD_CLK period of 4 CLK).
// A monitor watches SD_CLK edges to rebuild the transmitted frame and to
// count card clocks. A card model driven from the stimulus sequence answers
// on falling SD_CLK edges.
module tb_sd_cmd_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [5:0]   cmd_idx = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   resp_type = '0;
    logic         sd_clk;
    logic         cmd_out;
    logic         cmd_oe;
    logic         cmd_in = 1'b1;
    logic         busy;
    logic         done;
    logic         timeout;
    logic         crc_err;
    logic [127:0] resp;

    int compared = 0;
    int mismatched = 0;

    // Monitor state, written only by the monitor process.
    int          cyc = 0;
    int          sd_rises = 0;
    int          sd_falls = 0;
    int          tx_bits = 0;
    int          done_cnt = 0;
    int          oe_fall_mark = 0;
    int          done_rise_mark = 0;
    int          last_rise_cyc = 0;
    int          rise_period = 0;
    logic [47:0] tx_frame = '0;
    logic        prev_sd = 1'b0;
    logic        prev_oe = 1'b0;
    logic        prev_busy = 1'b0;

    sd_cmd_engine #(
        .CLK_DIV      (2),
        .INIT_CLOCKS  (80),
        .RESP_TIMEOUT (64),
        .GAP_CLOCKS   (8)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .CMD_IDX   (cmd_idx),
        .CMD_ARG   (cmd_arg),
        .RESP_TYPE (resp_type),
        .SD_CLK    (sd_clk),
        .CMD_OUT   (cmd_out),
        .CMD_OE    (cmd_oe),
        .CMD_IN    (cmd_in),
        .BUSY      (busy),
        .DONE      (done),
        .TIMEOUT   (timeout),
        .CRC_ERR   (crc_err),
        .RESP      (resp)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Monitor sampled 1 ns after each rising edge. The frame is rebuilt from
    // CMD_OUT at every SD_CLK rise while CMD_OE is high, and restarts
    // whenever BUSY goes high.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            sd_rises = 0;
            sd_falls = 0;
            tx_bits  = 0;
            tx_frame = '0;
            done_cnt = 0;
        end else begin
            if (!prev_sd && sd_clk) begin
                sd_rises++;
                rise_period   = cyc - last_rise_cyc;
                last_rise_cyc = cyc;
                if (cmd_oe) begin
                    tx_frame = {tx_frame[46:0], cmd_out};
                    tx_bits++;
                end
            end
            if (prev_sd && !sd_clk) begin
                sd_falls++;
            end
            if (!prev_busy && busy) begin
                tx_bits  = 0;
                tx_frame = '0;
            end
            if (prev_oe && !cmd_oe) begin
                oe_fall_mark = sd_rises;
            end
            if (done) begin
                done_cnt++;
                done_rise_mark = sd_rises;
            end
        end
        prev_sd   = sd_clk;
        prev_oe   = cmd_oe;
        prev_busy = busy;
    end

    // One comparison point: counts it, and on mismatch counts and reports it.
    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one command request for a single CLK while the engine is idle.
    task automatic apply_stimulus(input logic [5:0] idx, input logic [31:0] arg,
                                  input logic [1:0] rtype);
        @(negedge clk);
        cmd_idx   = idx;
        cmd_arg   = arg;
        resp_type = rtype;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic check_reset_values();
        check_output("rst_sd_clk",  128'(sd_clk),  128'd0);
        check_output("rst_cmd_out", 128'(cmd_out), 128'd1);
        check_output("rst_cmd_oe",  128'(cmd_oe),  128'd0);
        check_output("rst_busy",    128'(busy),    128'd1);
        check_output("rst_done",    128'(done),    128'd0);
        check_output("rst_timeout", 128'(timeout), 128'd0);
        check_output("rst_crc_err", 128'(crc_err), 128'd0);
        check_output("rst_resp",    resp,          128'd0);
    endtask

    // Releases reset and follows the power-up burst. BUSY drops on the edge
    // of the 80th SD_CLK rise, which is CLK edge 2 + 4*79 = 318.
    task automatic run_init();
        int   cycles = 0;
        logic oe_seen = 1'b0;
        rst = 1'b0;
        while (cycles < 1000) begin
            @(negedge clk);
            cycles++;
            if (cmd_oe) oe_seen = 1'b1;
            if (!busy) break;
        end
        check_output("init_cycles",  128'(cycles),      128'd318);
        check_output("init_rises",   128'(sd_rises),    128'd80);
        check_output("init_oe_seen", 128'(oe_seen),     128'd0);
        check_output("sd_period",    128'(rise_period), 128'd4);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 128'(done), 128'd1);
    endtask

    task automatic wait_frame_end();
        int   n = 0;
        logic found = 1'b0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (tx_bits == 48 && !cmd_oe) begin
                found = 1'b1;
                break;
            end
        end
        check_output("frame_end_seen", 128'(found), 128'd1);
    endtask

    // Card model: drives the low n bits of 'bits', MSB first, one bit after
    // each SD_CLK fall so the host sees it stable at the next rise.
    task automatic drive_reply(input logic [135:0] bits, input int n);
        int   f;
        int   guard;
        logic stalled = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            f = sd_falls;
            guard = 0;
            while (sd_falls == f && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (sd_falls == f) stalled = 1'b1;
            cmd_in = bits[i];
        end
        check_output("reply_paced", 128'(stalled), 128'd0);
    endtask

    initial begin
        int done_before;

        // Reset values while RST is held.
        repeat (3) @(negedge clk);
        check_reset_values();

        run_init();

        // CMD0, no response; a START pulse during SEND must be dropped.
        done_before = done_cnt;
        apply_stimulus(6'd0, 32'h0, 2'b00);
        repeat (20) @(negedge clk);
        cmd_idx   = 6'd8;
        resp_type = 2'b01;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cmd_idx   = 6'd0;
        resp_type = 2'b00;
        wait_done("cmd0_done", 3000);
        check_output("cmd0_busy_at_done", 128'(busy),     128'd0);
        check_output("cmd0_frame",        128'(tx_frame), 128'h400000000095);
        check_output("cmd0_bits",         128'(tx_bits),  128'd48);
        check_output("cmd0_gap_rises",    128'(done_rise_mark - oe_fall_mark), 128'd8);
        check_output("cmd0_timeout",      128'(timeout),  128'd0);
        check_output("cmd0_crc_err",      128'(crc_err),  128'd0);
        check_output("cmd0_resp",         resp,           128'd0);
        @(negedge clk);
        check_output("cmd0_done_width",   128'(done),     128'd0);
        repeat (40) @(negedge clk);
        check_output("cmd0_no_second_txn", 128'(busy),    128'd0);
        check_output("cmd0_done_count",   128'(done_cnt - done_before), 128'd1);

        // CMD8 with a correct R7 reply.
        apply_stimulus(6'd8, 32'h000001AA, 2'b01);
        wait_frame_end();
        check_output("cmd8_frame", 128'(tx_frame), 128'h48000001AA87);
        drive_reply(136'h08000001AA13, 48);
        wait_done("cmd8_done", 3000);
        check_output("cmd8_resp",    resp,          128'h08000001AA);
        check_output("cmd8_crc_err", 128'(crc_err), 128'd0);
        check_output("cmd8_timeout", 128'(timeout), 128'd0);

        // Same command, reply with a corrupted CRC field.
        apply_stimulus(6'd8, 32'h000001AA, 2'b01);
        wait_frame_end();
        drive_reply(136'h08000001AA15, 48);
        wait_done("badcrc_done", 3000);
        check_output("badcrc_crc_err", 128'(crc_err), 128'd1);
        check_output("badcrc_timeout", 128'(timeout), 128'd0);

        // No reply at all: 64 waiting rises then 8 gap rises, RESP kept.
        cmd_in = 1'b1;
        apply_stimulus(6'd8, 32'h000001AA, 2'b01);
        wait_done("tmo_done", 3000);
        check_output("tmo_timeout", 128'(timeout), 128'd1);
        check_output("tmo_crc_err", 128'(crc_err), 128'd0);
        check_output("tmo_resp",    resp,          128'h08000001AA);
        check_output("tmo_rises",   128'(done_rise_mark - oe_fall_mark), 128'd72);

        // CMD2 with a 136-bit R2 reply.
        apply_stimulus(6'd2, 32'h0, 2'b10);
        wait_frame_end();
        drive_reply({8'h3F, 128'h0123456789ABCDEFFEDCBA9876543211}, 136);
        wait_done("r2_done", 3000);
        check_output("r2_resp",    resp,          128'h0123456789ABCDEFFEDCBA9876543210);
        check_output("r2_crc_err", 128'(crc_err), 128'd0);
        check_output("r2_timeout", 128'(timeout), 128'd0);

        // Reset in the middle of receiving a response.
        apply_stimulus(6'd8, 32'h000001AA, 2'b01);
        wait_frame_end();
        drive_reply(136'h08000001AA13 >> 28, 20);
        check_output("midrecv_busy", 128'(busy), 128'd1);
        @(negedge clk);
        cmd_in = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        check_reset_values();
        run_init();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

endmodule
